// File: rtl/alu_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_seq_pkg
// Description : Shared types and constants for the ALU word sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

    localparam int c_nibble_w = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // SerialALU function selects shared with the instruction decoder
    localparam logic [3:0] ALU_S_ADD = 4'b1001;
    localparam logic [3:0] ALU_S_XOR = 4'b0110;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_nibble_mux.sv
//------------------------------------------------------------------------------
// Module      : alu_nibble_mux
// Description : Selects one 4-bit nibble out of a multi-nibble word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_nibble_mux
    import alu_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic [WORDS*c_nibble_w-1:0] word,
    input  logic [IDX_W-1:0]            sel,
    output logic [c_nibble_w-1:0]       nibble
);

    logic [c_nibble_w-1:0] w_nibs [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
            assign w_nibs[gi] = word[gi*c_nibble_w +: c_nibble_w];
        end
    endgenerate

    // Out-of-range selects return zero rather than wrapping
    always_comb begin
        nibble = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (sel == IDX_W'(i)) begin
                nibble = w_nibs[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_word_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_word_sequencer
// Description : Drives a 4-bit SerialALU nibble by nibble (LSB first) to build
//               4*WORDS-bit results with chained carry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_word_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*WORDS-1:0] op_a,
    input  logic [4*WORDS-1:0] op_b,
    input  logic [3:0]         op_s,
    input  logic               op_m,
    input  logic               op_cin,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] result,
    output logic               cout,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [3:0]         alu_s,
    output logic               alu_m,
    output logic               alu_pin,
    input  logic [3:0]         alu_r,
    input  logic [3:0]         alu_p
);

    localparam int                 c_width = c_nibble_w * WORDS;
    localparam int                 c_idx_w = idx_width(WORDS);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(WORDS - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;
    logic [3:0]           r_s;
    logic                 r_m;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_width-1:0]   r_result;
    logic                 r_cout;
    logic [3:0]           w_nib_a;
    logic [3:0]           w_nib_b;
    logic                 w_unused_p;

    // Only the nibble carry bit of P is meaningful to the sequencer
    assign w_unused_p = ^alu_p[2:0];

    alu_nibble_mux #(
        .WORDS (WORDS),
        .IDX_W (c_idx_w)
    ) u_mux_a (
        .word   (r_a),
        .sel    (r_idx),
        .nibble (w_nib_a)
    );

    alu_nibble_mux #(
        .WORDS (WORDS),
        .IDX_W (c_idx_w)
    ) u_mux_b (
        .word   (r_b),
        .sel    (r_idx),
        .nibble (w_nib_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_m      <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_s     <= op_s;
                        r_m     <= op_m;
                        r_carry <= op_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_idx == c_idx_w'(i)) begin
                            r_result[i*c_nibble_w +: c_nibble_w] <= alu_r;
                        end
                    end
                    r_carry <= alu_p[3];
                    if (r_idx == c_last) begin
                        r_cout <= alu_p[3];
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + c_idx_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU-facing outputs are forced to zero outside RUN
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_s        = '0;
        alu_m        = 1'b0;
        alu_pin      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                alu_a   = w_nib_a;
                alu_b   = w_nib_b;
                alu_s   = r_s;
                alu_m   = r_m;
                alu_pin = r_carry;
                if (r_idx == c_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign result = r_result;
    assign cout   = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_alu_word_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_word_sequencer
// Description : Directed self-checking bench with a behavioural SerialALU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_word_sequencer;
    import alu_seq_pkg::*;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  op_s;
    logic        op_m;
    logic        op_cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_pin;
    logic [3:0]  alu_r;
    logic [3:0]  alu_p;
    logic [4:0]  sum;

    int checks   = 0;
    int failures = 0;

    alu_word_sequencer #(.WORDS(WORDS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .op_s    (op_s),
        .op_m    (op_m),
        .op_cin  (op_cin),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_s   (alu_s),
        .alu_m   (alu_m),
        .alu_pin (alu_pin),
        .alu_r   (alu_r),
        .alu_p   (alu_p)
    );

    always #5 clk = ~clk;

    // Behavioural SerialALU: add-with-carry and logic XOR
    always_comb begin
        sum   = 5'd0;
        alu_r = 4'd0;
        alu_p = 4'd0;
        if (alu_s == ALU_S_ADD && !alu_m) begin
            sum   = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_pin};
            alu_r = sum[3:0];
            alu_p = {sum[4], 3'b000};
        end else if (alu_s == ALU_S_XOR && alu_m) begin
            alu_r = alu_a ^ alu_b;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation at the current negedge; returns at the done cycle
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cin,
                         output int lat, output logic [3:0] pins, output logic smok);
        op_a   = a;
        op_b   = b;
        op_s   = s;
        op_m   = m;
        op_cin = cin;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        pins  = 4'd0;
        smok  = 1'b1;
        while (done !== 1'b1 && lat < 20) begin
            if (lat <= 4) begin
                pins[lat-1] = alu_pin;
                if (!(alu_s === s && alu_m === m && busy === 1'b1)) smok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         dones;
        logic [3:0] pins;
        logic       smok;

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        op_s = '0; op_m = 1'b0; op_cin = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_state", 64'({busy, done, cout, result}), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_outputs", 64'({busy, done, cout, result, alu_a, alu_b, alu_s, alu_m, alu_pin}), 64'd0);
        end

        do_op(16'h0FFF, 16'h0001, ALU_S_ADD, 1'b0, 1'b0, lat, pins, smok);
        check("add_latency", 64'(lat), 64'd5);
        check("add_result", 64'(result), 64'h1000);
        check("add_cout", 64'(cout), 64'd0);
        check("add_pin_seq", 64'(pins), 64'b1110);
        check("add_sel_mode", 64'(smok), 64'd1);
        @(negedge clk);
        check("done_one_cycle", 64'({done, busy}), 64'd0);

        do_op(16'hFFFF, 16'h0000, ALU_S_ADD, 1'b0, 1'b1, lat, pins, smok);
        check("ovf_latency", 64'(lat), 64'd5);
        check("ovf_result", 64'(result), 64'h0000);
        check("ovf_cout", 64'(cout), 64'd1);
        check("ovf_pin_seq", 64'(pins), 64'b1111);
        @(negedge clk);

        do_op(16'h1234, 16'h4321, ALU_S_ADD, 1'b0, 1'b0, lat, pins, smok);
        check("b2b_latency", 64'(lat), 64'd5);
        check("b2b_result", 64'(result), 64'h5555);
        check("b2b_cout", 64'(cout), 64'd0);
        @(negedge clk);
        check("idle_alu_zero", 64'({alu_a, alu_b, alu_s, alu_m, alu_pin, busy}), 64'd0);
        check("result_held", 64'(result), 64'h5555);

        do_op(16'hA5A5, 16'hFF00, ALU_S_XOR, 1'b1, 1'b0, lat, pins, smok);
        check("xor_latency", 64'(lat), 64'd5);
        check("xor_result", 64'(result), 64'h5AA5);
        check("xor_cout", 64'(cout), 64'd0);
        check("xor_sel_mode", 64'(smok), 64'd1);
        @(negedge clk);

        op_a = 16'h0001; op_b = 16'h0002; op_s = ALU_S_ADD; op_m = 1'b0; op_cin = 1'b0;
        start = 1'b1;
        dones = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            dones += int'(done);
            op_a = op_a + 16'h1111;
        end
        check("ign_done_at_5", 64'(done), 64'd1);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("ign_done_count", 64'(dones), 64'd1);
        check("ign_result", 64'(result), 64'h0003);
        check("ign_idle", 64'(busy), 64'd0);

        op_a = 16'h0FFF; op_b = 16'h0001; op_cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_state", 64'({busy, done, cout, result, alu_a, alu_pin}), 64'd0);
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("rst_no_done", 64'(dones), 64'd0);

        do_op(16'h1234, 16'h4321, ALU_S_ADD, 1'b0, 1'b0, lat, pins, smok);
        check("post_rst_latency", 64'(lat), 64'd5);
        check("post_rst_result", 64'(result), 64'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
